// File: rtl/add_top.sv
// add_top: ripple-carry two's-complement adder/subtractor with signed overflow and registered/sticky copies
module add_top #(
    parameter int WIDTH = 6
) (
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic [WIDTH-1:0] out_q,
    output logic             overflow_q,
    output logic             overflow_sticky,
    input  logic             clk,
    input  logic             rst
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] out_d;
    logic             overflow_d;
    logic             overflow_sticky_d;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign bx[i]   = b[i] ^ cin;
        assign out[i]  = a[i] ^ bx[i] ^ c[i];
        assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    assign overflow = c[WIDTH] ^ c[WIDTH-1];
    always_comb begin
        out_d             = rst ? '0 : out;
        overflow_d        = rst ? 1'b0 : overflow;
        overflow_sticky_d = rst ? 1'b0 : (overflow_sticky | overflow);
    end
    always_ff @(posedge clk) begin
        out_q           <= out_d;
        overflow_q      <= overflow_d;
        overflow_sticky <= overflow_sticky_d;
    end
endmodule

// File: tb/tb_add_top.sv
// tb_add_top: scoreboard bench for add_top; driver queues expectations, monitor pops on each sample strobe
module tb_add_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cin = 1'b0;
    logic [5:0] a = '0;
    logic [5:0] b = '0;
    logic [5:0] out;
    logic       overflow;
    logic [5:0] out_q;
    logic       overflow_q;
    logic       overflow_sticky;
    logic       smp = 1'b0;
    logic       done = 1'b0;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        string      nm;
        bit         is_reg;
        logic [5:0] o;
        logic       ov;
        logic       st;
    } exp_t;
    exp_t sb_q[$];

    add_top #(.WIDTH(6)) dut (
        .cin(cin), .a(a), .b(b), .out(out), .overflow(overflow),
        .out_q(out_q), .overflow_q(overflow_q), .overflow_sticky(overflow_sticky),
        .clk(clk), .rst(rst)
    );

    always #5 clk = ~clk;

    always @(posedge smp or posedge done) begin
        if (done) begin
            if (sb_q.size() != 0) begin
                tests++;
                fails++;
                $display("FAIL leftover: %0d expectations never checked, required 0", sb_q.size());
            end
        end else if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL strobe: sample with empty scoreboard");
        end else begin
            exp_t e;
            e = sb_q.pop_front();
            tests++;
            if (e.is_reg) begin
                if (out_q !== e.o || overflow_q !== e.ov || overflow_sticky !== e.st) begin
                    fails++;
                    $display("FAIL %s: out_q=%0d ovq=%b sticky=%b, required out_q=%0d ovq=%b sticky=%b",
                             e.nm, $signed(out_q), overflow_q, overflow_sticky, $signed(e.o), e.ov, e.st);
                end
            end else if (out !== e.o || overflow !== e.ov) begin
                fails++;
                $display("FAIL %s: a=%0d b=%0d cin=%b out=%0d ov=%b, required out=%0d ov=%b",
                         e.nm, $signed(a), $signed(b), cin, $signed(out), overflow, $signed(e.o), e.ov);
            end
        end
    end

    task automatic strobe();
        smp = 1'b1;
        #1;
        smp = 1'b0;
    endtask

    task automatic chk_comb(input string nm, input int ea, input int eb, input bit ec,
                            input int eo, input bit eov);
        exp_t e;
        a = 6'(ea);
        b = 6'(eb);
        cin = ec;
        #10;
        e.nm = nm; e.is_reg = 1'b0; e.o = 6'(eo); e.ov = eov; e.st = 1'b0;
        sb_q.push_back(e);
        strobe();
    endtask

    task automatic chk_reg(input string nm, input int eo, input bit eov, input bit est);
        exp_t e;
        e.nm = nm; e.is_reg = 1'b1; e.o = 6'(eo); e.ov = eov; e.st = est;
        sb_q.push_back(e);
        strobe();
    endtask

    task automatic edge_then(input int na, input int nb, input bit nrst);
        @(negedge clk);
        a = 6'(na);
        b = 6'(nb);
        cin = 1'b0;
        rst = nrst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int x = -32; x < 32; x++)
                for (int y = -32; y < 32; y++) begin
                    int s;
                    s = (c == 0) ? x + y : x - y;
                    chk_comb(c == 0 ? "exh_add" : "exh_sub", x, y, c[0], s, (s > 31 || s < -32));
                end
        chk_comb("add_31p1", 31, 1, 0, -32, 1);
        chk_comb("add_m32m1", -32, -1, 0, 31, 1);
        chk_comb("add_m32p31", -32, 31, 0, -1, 0);
        chk_comb("add_m32p0", -32, 0, 0, -32, 0);
        chk_comb("add_10p5", 10, 5, 0, 15, 0);
        chk_comb("sub_5m7", 5, 7, 1, -2, 0);
        chk_comb("sub_m32m1", -32, 1, 1, 31, 1);
        chk_comb("sub_0mm32", 0, -32, 1, -32, 1);
        chk_comb("sub_m1mm1", -1, -1, 1, 0, 0);

        edge_then(0, 0, 1);
        edge_then(0, 0, 1);
        chk_reg("reset_hold", 0, 0, 0);
        edge_then(3, 4, 0);
        chk_reg("reg_3p4", 7, 0, 0);
        edge_then(31, 1, 0);
        chk_reg("reg_ovf", -32, 1, 1);
        edge_then(1, 1, 0);
        chk_reg("reg_sticky_hold", 2, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        a = 6'd31;
        b = 6'd1;
        #1;
        chk_reg("sticky_before_edge", 2, 0, 1);
        chk_comb("rst_comb_pre", 31, 1, 0, -32, 1);
        @(posedge clk);
        #1;
        chk_reg("rst_mid_stream", 0, 0, 0);
        chk_comb("rst_comb_post", 31, 1, 0, -32, 1);
        edge_then(31, 1, 0);
        chk_reg("sticky_reset_again", -32, 1, 1);

        #1;
        done = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
